// File: rtl/d_latch.sv
// Level-sensitive D latch: transparent while clk is high, holding while clk is low.
// Reset only clears the output during the transparent phase.
module d_latch #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Reset outranks data, but it is only looked at while the latch is open.
    assign q_d = reset ? '0 : d;

    always_latch begin
        if (clk) begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_d_latch.sv
// Directed bench for d_latch: a vector table walked in order, plus short
// sequences for mid-phase reset and data changes.
module tb_d_latch;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             clk;
        logic             reset;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] q;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    d_latch #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .reset(reset),
        .d    (d),
        .q    (q)
    );

    task automatic applyStimulus(input logic c, input logic r, input logic [WIDTH-1:0] dv);
        clk   = c;
        reset = r;
        d     = dv;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] expQ);
        checks++;
        if (q !== expQ) begin
            errors++;
            $display("[TB] FAIL %s: q=%h expected %h", name, q, expQ);
        end
    endtask

    initial begin
        // Each row carries state from the previous one, so order matters.
        vecs[0]  = '{1'b1, 1'b1, 4'h0, 4'h0};
        vecs[1]  = '{1'b0, 1'b1, 4'hF, 4'h0};
        vecs[2]  = '{1'b1, 1'b1, 4'hF, 4'h0};
        vecs[3]  = '{1'b1, 1'b0, 4'h0, 4'h0};
        vecs[4]  = '{1'b0, 1'b0, 4'h5, 4'h0};
        vecs[5]  = '{1'b1, 1'b0, 4'h5, 4'h5};
        vecs[6]  = '{1'b1, 1'b0, 4'hA, 4'hA};
        vecs[7]  = '{1'b0, 1'b0, 4'hA, 4'hA};
        vecs[8]  = '{1'b0, 1'b0, 4'h3, 4'hA};
        vecs[9]  = '{1'b0, 1'b1, 4'h3, 4'hA};
        vecs[10] = '{1'b1, 1'b1, 4'h3, 4'h0};
        vecs[11] = '{1'b1, 1'b0, 4'h3, 4'h3};
        vecs[12] = '{1'b1, 1'b1, 4'hC, 4'h0};
        vecs[13] = '{1'b1, 1'b0, 4'h6, 4'h6};
        vecs[14] = '{1'b0, 1'b0, 4'h9, 4'h6};
        vecs[15] = '{1'b1, 1'b0, 4'h9, 4'h9};

        // q is unknown until the first transparent phase, so nothing is checked here.
        clk = 1'b0; reset = 1'b0; d = '0;
        #4;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].clk, vecs[i].reset, vecs[i].d);
            checkOutput($sformatf("vec%0d", i), vecs[i].q);
            #1;
        end

        // Transparent tracking of data toggles at 2 ns spacing.
        applyStimulus(1'b1, 1'b0, 4'h0);
        checkOutput("track0", 4'h0);
        #1;
        applyStimulus(1'b1, 1'b0, 4'hF);
        checkOutput("track1", 4'hF);
        #1;
        applyStimulus(1'b1, 1'b0, 4'h0);
        checkOutput("track2", 4'h0);
        #1;

        // Hold through d and reset changes while closed, then reset on reopening.
        applyStimulus(1'b1, 1'b0, 4'hF);
        checkOutput("open_hold_src", 4'hF);
        applyStimulus(1'b0, 1'b0, 4'hF);
        checkOutput("closed_hold", 4'hF);
        applyStimulus(1'b0, 1'b1, 4'h0);
        checkOutput("closed_ignore_rst", 4'hF);
        applyStimulus(1'b1, 1'b1, 4'h0);
        checkOutput("reopen_rst", 4'h0);

        // Reset pulse in the middle of a transparent phase, with bit-distinct data.
        applyStimulus(1'b1, 1'b0, 4'hB);
        checkOutput("mid_pre", 4'hB);
        applyStimulus(1'b1, 1'b1, 4'hB);
        checkOutput("mid_rst_on", 4'h0);
        applyStimulus(1'b1, 1'b0, 4'hB);
        checkOutput("mid_rst_off", 4'hB);
        applyStimulus(1'b0, 1'b0, 4'h4);
        checkOutput("final_hold", 4'hB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_latch.md
D_LATCH -- requirements
Module: d_latch

Interface
REQ-001 Parameter: WIDTH, default 1, data width of d and q in bits.
REQ-002 Port: clk  input  1  level-sensitive enable; the latch is transparent while clk=1 and holds while clk=0; this is the block's only clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: d  input  WIDTH  data input.
REQ-005 Port: q  output  WIDTH  latched data output.
REQ-006 The port names, directions and widths SHALL be exactly as listed in REQ-002 to REQ-005, with no further ports.

Function
REQ-007 While clk=1 and reset=0, q SHALL equal d combinationally, with zero delay and no register stage.
REQ-008 While clk=1 and reset=0, q SHALL follow every change of d.
REQ-009 While clk=1 and reset=1, q SHALL be all zeros regardless of d.
REQ-010 While clk=0, q SHALL hold the value present at the falling edge of clk.
REQ-011 While clk=0, changes on d SHALL NOT affect q.
REQ-012 While clk=0, changes on reset SHALL NOT affect q.
REQ-013 On the falling edge of clk, q SHALL capture the d value (or zero, if reset=1) present just before the edge.
REQ-014 When clk rises, q SHALL update immediately to d (reset=0) or to zero (reset=1).
REQ-015 Reset SHALL take priority over d whenever clk=1.
REQ-016 If reset and d change simultaneously while clk=1, q SHALL settle to the value given by the final reset/d levels.
REQ-017 If reset rises mid-transparent-phase, q SHALL clear to zero at once.
REQ-018 If reset falls mid-transparent-phase, q SHALL take d at once.
REQ-019 All WIDTH bits SHALL behave independently and identically.
REQ-020 The design SHALL contain no edge-triggered storage; it is a pure level-sensitive latch.
REQ-021 The design SHALL be glitch-tolerant: no other internal state exists.

Reset
REQ-022 Reset SHALL be synchronous to clk: it SHALL act only while clk=1.
REQ-023 The reset value of q SHALL be all zeros.
REQ-024 At power-up, before the first clk=1 phase, q SHALL be unknown (X in simulation), and the bench SHALL NOT check q in this interval.
REQ-025 Reset asserted only while clk=0 SHALL leave q unchanged until clk next rises.

Verification
REQ-026 reset=1, d=0, clk 0->1 -> q=0.
REQ-027 reset=1, d=1, clk=0 then clk=1 -> q stays 0 (reset dominates d).
REQ-028 reset=0, d=0, clk=1 -> q=0; then d=1 with clk=0 -> q holds 0; then clk=1 -> q=1.
REQ-029 reset=0, clk=1, toggle d 0->1->0 at 2 ns intervals -> q tracks d each time with no delay.
REQ-030 clk=1, d=1 so q=1; drop clk to 0; set d=0 and reset=1 -> q holds 1; raise clk -> q=0.
REQ-031 reset=0, d=1, clk=1 so q=1; assert reset while clk=1 -> q=0 immediately; deassert reset -> q=1.
